// File: rtl/mips_pkg.sv
// Shared definitions for the sequential right shifter: FSM state encoding,
// shift-op encodings and default datapath sizing.
package mips_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic OP_SRL = 1'b0;
    localparam logic OP_SRA = 1'b1;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_SHW   = 5;

endpackage : mips_pkg

// File: rtl/shift_right_seq_if.sv
// Request/response bundle for shift_right_seq. The requester (master) drives
// start/op/shamt/data_in; the shifter (slave) returns busy/done/data_out.
interface shift_right_seq_if
    import mips_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SHW   = DEF_SHW
);
    logic             start;
    logic             op;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] data_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] data_out;

    modport master (
        output start, op, shamt, data_in,
        input  busy, done, data_out
    );

    modport slave (
        input  start, op, shamt, data_in,
        output busy, done, data_out
    );
endinterface : shift_right_seq_if

// File: rtl/shift_right_seq.sv
// Sequential right shifter: one bit per clock, shamt clocks per operation.
// Optional feature macro: SHIFT_SRA_EN -- when defined, op=OP_SRA fills with
// the operand sign bit; otherwise op is ignored and every shift is logical.
//
// state | meaning
// IDLE  | waiting for start; result of last operation held on data_out
// SHIFT | shifting working register right by one bit per edge
// DONE  | single-cycle completion, done pulse high, start ignored
module shift_right_seq
    import mips_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SHW   = DEF_SHW
) (
    input  logic              clk,
    input  logic              rst_n,
    shift_right_seq_if.slave  bus
);

    state_t           state_q, state_d;
    logic [SHW-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic             fill;

`ifdef SHIFT_SRA_EN
    logic op_q, op_d;

    // Captured op register, only needed when sign fill is available.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q <= OP_SRL;
        end else begin
            op_q <= op_d;
        end
    end

    // Capture op on an accepted start; hold it for the whole operation.
    always_comb begin
        op_d = op_q;
        if (state_q == IDLE && bus.start) begin
            op_d = bus.op;
        end
    end

    // The MSB never changes under an arithmetic shift, so it is the captured sign.
    assign fill = (op_q == OP_SRA) ? work_q[WIDTH-1] : 1'b0;
`else
    assign fill = 1'b0;
`endif

    // State, remaining-count and working-register flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            work_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            work_q  <= work_d;
        end
    end

    // Next-state, down-counter and shift datapath.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        work_d  = work_q;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    work_d  = bus.data_in;
                    cnt_d   = bus.shamt;
                    state_d = (bus.shamt == '0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                work_d = {fill, work_q[WIDTH-1:1]};
                cnt_d  = cnt_q - 1'b1;
                if (cnt_q == SHW'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.busy     = (state_q != IDLE);
    assign bus.done     = (state_q == DONE);
    assign bus.data_out = work_q;

endmodule : shift_right_seq

// File: tb/tb_shift_right_seq.sv
// Directed bench for shift_right_seq: table of vectors run back-to-back,
// hand-written sequences for ignored starts and mid-operation reset, then
// pseudo-random operations checked against the >> / >>> operators.
module tb_shift_right_seq;

    localparam int WIDTH = 32;
    localparam int SHW   = 5;
`ifdef SHIFT_SRA_EN
    localparam bit SRA_EN = 1'b1;
`else
    localparam bit SRA_EN = 1'b0;
`endif

    typedef struct {
        logic [31:0] data;
        logic        op;
        logic [4:0]  sh;
        logic [31:0] exp;
    } vec_t;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    shift_right_seq_if #(.WIDTH(WIDTH), .SHW(SHW)) bus ();

    shift_right_seq #(.WIDTH(WIDTH), .SHW(SHW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_shift(logic [31:0] d, logic o, int sh);
        if (SRA_EN && o) return $unsigned($signed(d) >>> sh);
        return d >> sh;
    endfunction

    // Called at a negedge while the DUT is idle; returns at the negedge of the
    // IDLE cycle following DONE, so a chained call issues a back-to-back start.
    task automatic run_op(input string name, input logic [31:0] d, input logic o,
                          input logic [4:0] sh, input logic [31:0] exp);
        int  k;
        int  bcnt;
        bit  seen;
        bcnt = 0;
        seen = 1'b0;
        bus.start   = 1'b1;
        bus.data_in = d;
        bus.op      = o;
        bus.shamt   = sh;
        @(posedge clk);
        #1;
        bus.start   = 1'b0;
        bus.data_in = ~d;
        bus.op      = ~o;
        bus.shamt   = ~sh;
        @(negedge clk);
        for (k = 0; k < 40; k++) begin
            if (bus.busy) bcnt++;
            if (bus.done) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check({name, " done_seen"}, 32'(seen), 32'd1);
        check({name, " latency"}, 32'(k), 32'(sh));
        check({name, " busy_cycles"}, 32'(bcnt), 32'(sh) + 32'd1);
        check({name, " result"}, bus.data_out, exp);
        @(negedge clk);
        check({name, " idle_after"}, {30'd0, bus.busy, bus.done}, 32'd0);
        check({name, " held"}, bus.data_out, exp);
    endtask

    vec_t vecs[10];

    initial begin
        int          dones;
        logic [31:0] at_done;
        logic [31:0] rd;
        logic        ro;
        logic [4:0]  rs;
        bit          seen;

        n_tests = 0;
        n_fail  = 0;

        vecs[0] = '{32'h80000010, 1'b0, 5'd4,  32'h08000001};
        vecs[1] = '{32'h80000010, 1'b1, 5'd4,  SRA_EN ? 32'hF8000001 : 32'h08000001};
        vecs[2] = '{32'h12345678, 1'b0, 5'd0,  32'h12345678};
        vecs[3] = '{32'hFFFFFFFF, 1'b0, 5'd31, 32'h00000001};
        vecs[4] = '{32'hFFFFFFFF, 1'b1, 5'd31, SRA_EN ? 32'hFFFFFFFF : 32'h00000001};
        vecs[5] = '{32'h00000F00, 1'b0, 5'd8,  32'h0000000F};
        vecs[6] = '{32'hAABBCCDD, 1'b0, 5'd8,  32'h00AABBCC};
        vecs[7] = '{32'h7FFFFFFF, 1'b1, 5'd1,  32'h3FFFFFFF};
        vecs[8] = '{32'h80000001, 1'b0, 5'd1,  32'h40000000};
        vecs[9] = '{32'h80000000, 1'b1, 5'd16, SRA_EN ? 32'hFFFF8000 : 32'h00008000};

        rst_n       = 1'b0;
        bus.start   = 1'b0;
        bus.op      = 1'b0;
        bus.shamt   = '0;
        bus.data_in = '0;
        repeat (3) @(negedge clk);
        check("reset busy/done", {30'd0, bus.busy, bus.done}, 32'd0);
        check("reset data_out", bus.data_out, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Table vectors, chained back-to-back.
        for (int i = 0; i < 10; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].data, vecs[i].op, vecs[i].sh, vecs[i].exp);
        end

        // Second start mid-operation is ignored; exactly one done.
        bus.start = 1'b1; bus.data_in = 32'hAABBCCDD; bus.op = 1'b0; bus.shamt = 5'd8;
        @(posedge clk); #1; bus.start = 1'b0;
        repeat (3) @(negedge clk);
        bus.start = 1'b1; bus.data_in = 32'h11111111; bus.shamt = 5'd2;
        @(posedge clk); #1; bus.start = 1'b0; bus.data_in = 32'h22222222;
        dones   = 0;
        at_done = '0;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            if (bus.done) begin
                dones++;
                at_done = bus.data_out;
            end
        end
        check("ignore_busy dones", 32'(dones), 32'd1);
        check("ignore_busy result", at_done, 32'h00AABBCC);
        check("ignore_busy no_queue", 32'(bus.busy), 32'd0);

        // Start presented during the DONE cycle is ignored.
        bus.start = 1'b1; bus.data_in = 32'h000000F0; bus.op = 1'b0; bus.shamt = 5'd2;
        @(posedge clk); #1; bus.start = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (bus.done) begin
                seen = 1'b1;
                break;
            end
        end
        check("done_cycle seen", 32'(seen), 32'd1);
        bus.start = 1'b1; bus.data_in = 32'hDEADBEEF; bus.shamt = 5'd0;
        @(posedge clk); #1; bus.start = 1'b0;
        @(negedge clk);
        check("done_cycle start ignored", {30'd0, bus.busy, bus.done}, 32'd0);
        check("done_cycle result", bus.data_out, 32'h0000003C);

        // Reset mid-operation aborts without a done pulse.
        bus.start = 1'b1; bus.data_in = 32'h12345678; bus.op = 1'b0; bus.shamt = 5'd10;
        @(posedge clk); #1; bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("pre_reset busy", 32'(bus.busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("async_reset busy/done", {30'd0, bus.busy, bus.done}, 32'd0);
        check("async_reset data_out", bus.data_out, 32'd0);
        dones = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (bus.done) dones++;
        end
        check("reset no_done", 32'(dones), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        run_op("post_reset", 32'h00000F00, 1'b0, 5'd8, 32'h0000000F);

        // Pseudo-random back-to-back operations.
        for (int i = 0; i < 20; i++) begin
            rd = $urandom;
            ro = 1'($urandom_range(0, 1));
            rs = 5'($urandom_range(0, 31));
            run_op($sformatf("rand%0d", i), rd, ro, rs, ref_shift(rd, ro, int'(rs)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_shift_right_seq

// File: doc/shift_right_seq.md
SHIFT_RIGHT_SEQ -- requirements
Module: shift_right_seq

Interface
REQ-001 SHALL expose parameter WIDTH, default 32, datapath width in bits.
REQ-002 SHALL expose parameter SHW, default 5, shift-amount width, i.e. log2(WIDTH).
REQ-003 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  request, sampled only in IDLE.
REQ-006 SHALL have port op  input  1  0 = logical right shift (srl), 1 = arithmetic right shift (sra).
REQ-007 SHALL have port shamt  input  SHW  shift amount, 0..WIDTH-1.
REQ-008 SHALL have port data_in  input  WIDTH  operand.
REQ-009 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-010 SHALL have port done  output  1  one-cycle completion pulse.
REQ-011 SHALL have port data_out  output  WIDTH  result, held stable until the next accepted start.

Function
REQ-012 SHALL implement FSM states IDLE, SHIFT, DONE.
REQ-013 When start=1 is sampled in IDLE at edge N, SHALL capture data_in, op and shamt into internal registers; later input changes have no effect.
REQ-014 IDLE->DONE when captured shamt=0; IDLE->SHIFT otherwise.
REQ-015 In SHIFT, each edge SHALL shift the working register right by exactly 1 bit and decrement the remaining count.
REQ-016 Fill bit SHALL be 0 for op=0, and the captured bit [WIDTH-1] for op=1.
REQ-017 SHIFT->DONE on the edge where the count goes from 1 to 0, so exactly shamt shift edges occur.
REQ-018 done SHALL be high for exactly the one cycle following edge N+shamt, giving latency shamt+1 cycles from the start edge.
REQ-019 DONE->IDLE unconditionally on the next edge.
REQ-020 data_out SHALL equal the working register; the final result SHALL remain valid from DONE until the next accepted start.
REQ-021 start while busy=1, including the DONE cycle, SHALL be ignored, with no queuing.
REQ-022 Back-to-back operation: start sampled in the cycle after DONE (state IDLE) SHALL be accepted.
REQ-023 shamt=WIDTH-1 SHALL produce a result equal to the single-cycle operator reference (>> or >>>); there is no overflow of the count.

Reset
REQ-024 rst_n=0 SHALL immediately force state=IDLE, busy=0, done=0, data_out=0 and count=0, regardless of clk.
REQ-025 Reset asserted mid-operation SHALL abort the operation; no done pulse is produced for it.
REQ-026 After rst_n deasserts, the first accepted start SHALL behave identically to a start after power-up.

Configuration
REQ-027 Macro SHIFT_SRA_EN, when defined, SHALL enable the sign-fill path of REQ-016 for op=1.
REQ-028 Without SHIFT_SRA_EN, op SHALL be ignored, all shifts SHALL be logical with 0 fill, and timing SHALL be unchanged.

Structure
REQ-029 Shared package mips_pkg SHALL hold the FSM state enum typedef (IDLE/SHIFT/DONE), the op encodings (OP_SRL=0, OP_SRA=1) and the default WIDTH/SHW constants.
REQ-030 Block SHALL be a single module; no sub-module is warranted. FSM, down-counter and shift register SHALL reside in one file.

Verification
REQ-031 data_in=0x80000010, op=0, shamt=4, start for 1 cycle -> done exactly 5 cycles after the start edge, data_out=0x08000001, busy high for 5 cycles.
REQ-032 With SHIFT_SRA_EN defined: data_in=0x80000010, op=1, shamt=4 -> data_out=0xF8000001. Without the macro -> 0x08000001.
REQ-033 data_in=0x12345678, shamt=0 -> done in the cycle after the start edge, data_out=0x12345678. Then data_in=0xFFFFFFFF, op=0, shamt=31 -> data_out=0x00000001 after 32 cycles.
REQ-034 Start shamt=8 on 0xAABBCCDD, pulse start again and change data_in at cycle 3 -> second start ignored, data_out=0x00AABBCC, single done pulse.
REQ-035 Start shamt=10, drop rst_n at cycle 4 -> busy, done and data_out go to 0 asynchronously with no done. After release, start 0x00000F00 with shamt=8 -> data_out=0x0000000F.
REQ-036 Random op/shamt/data_in with back-to-back starts issued the cycle after each done -> every result matches the single-cycle operator reference, every latency equals shamt+1.
